// File: rtl/mux_sel_scanner.sv
// rtl/mux_sel_scanner.sv - sequences a 4-input mux select, samples each channel, hands off a 4-bit word
//
// Optional feature macro: MUX_SCAN_CONTINUOUS_EN
//   defined   : a completed handshake immediately launches the next scan (busy stays high)
//   undefined : a completed handshake returns to IDLE; every scan needs its own start
//
// Per channel: SETTLE_CYC cycles in SETTLE followed by one SAMPLE cycle.
// SETTLE_CYC must lie in 1..15 so the settle counter fits in 4 bits.

module mux_sel_scanner #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic       busy,
  output logic       scan_valid,
  input  logic       scan_ready,
  output logic [3:0] scan_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Last settle count before moving to SAMPLE.
  localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [1:0] LP_SEL_LAST = 2'd3;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_cnt;
  logic [1:0] r_sel;
  logic       r_busy;
  logic       r_valid;
  logic [3:0] r_data;

  logic [3:0] w_cnt_nxt;
  logic [1:0] w_sel_nxt;
  logic       w_busy_nxt;
  logic       w_valid_nxt;
  logic [3:0] w_data_nxt;

  logic       w_handshake;
  logic       w_settle_done;
  logic       w_last_chan;

  // Handshake only counts while the completed word is on display.
  assign w_handshake   = (r_state == ST_HOLD) && r_valid && scan_ready;
  assign w_settle_done = (r_cnt == LP_CNT_LAST);
  assign w_last_chan   = (r_sel == LP_SEL_LAST);

  // State and datapath registers; reset aborts any scan and clears the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_sel   <= 2'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state decode: IDLE -> SETTLE -> SAMPLE -> (SETTLE | HOLD) -> IDLE or SETTLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_settle_done) begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (w_last_chan) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_HOLD: begin
        if (w_handshake) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
          w_state_nxt = ST_SETTLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values for the registered outputs and the settle counter; everything holds by default.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    case (r_state)
      ST_IDLE: begin
        // start is only looked at here, so a start during a scan is simply dropped.
        if (start) begin
          w_sel_nxt  = 2'd0;
          w_cnt_nxt  = 4'd0;
          w_busy_nxt = 1'b1;
        end
      end
      ST_SETTLE: begin
        // Cannot overflow: the counter stops advancing once SAMPLE is entered (max 15).
        w_cnt_nxt = r_cnt + 4'd1;
      end
      ST_SAMPLE: begin
        // Only the current channel's bit changes; older bits keep the previous scan.
        w_data_nxt[r_sel] = mux_out;
        if (w_last_chan) begin
          w_valid_nxt = 1'b1;
        end else begin
          w_sel_nxt = r_sel + 2'd1;
          w_cnt_nxt = 4'd0;
        end
      end
      ST_HOLD: begin
        // sel and the word stay frozen until the consumer takes the word.
        if (w_handshake) begin
          w_valid_nxt = 1'b0;
          w_sel_nxt   = 2'd0;
`ifdef MUX_SCAN_CONTINUOUS_EN
          w_cnt_nxt   = 4'd0;
`else
          w_busy_nxt  = 1'b0;
`endif
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_sel_nxt   = 2'd0;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign sel        = r_sel;
  assign busy       = r_busy;
  assign scan_valid = r_valid;
  assign scan_data  = r_data;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb/tb_mux_sel_scanner.sv - directed checks of mux_sel_scanner at SETTLE_CYC 1 and 3

module tb_mux_sel_scanner;

  logic       clk;
  logic       rst_n;

  logic       start1, ready1, mux1;
  logic [1:0] sel1;
  logic       busy1, valid1;
  logic [3:0] data1;
  logic [3:0] pat1;

  logic       start3, ready3, mux3;
  logic [1:0] sel3;
  logic       busy3, valid3;
  logic [3:0] data3;
  logic [3:0] pat3;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MUX_SCAN_CONTINUOUS_EN
  localparam logic EXP_BUSY_AFTER_HS = 1'b1;
`else
  localparam logic EXP_BUSY_AFTER_HS = 1'b0;
`endif

  // Mux stage model: bit i of the pattern is the input selected by sel == i.
  assign mux1 = pat1[sel1];
  assign mux3 = pat3[sel3];

  mux_sel_scanner #(.SETTLE_CYC(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .mux_out    (mux1),
    .sel        (sel1),
    .busy       (busy1),
    .scan_valid (valid1),
    .scan_ready (ready1),
    .scan_data  (data1)
  );

  mux_sel_scanner #(.SETTLE_CYC(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start3),
    .mux_out    (mux3),
    .sel        (sel3),
    .busy       (busy3),
    .scan_valid (valid3),
    .scan_ready (ready3),
    .scan_data  (data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_sel;
    rst_n  = 1'b0;
    start1 = 1'b0; ready1 = 1'b0; pat1 = 4'b1101;
    start3 = 1'b0; ready3 = 1'b0; pat3 = 4'b1010;

    // Reset state
    #2;
    check("rst_sel",   32'(sel1),   32'd0);
    check("rst_busy",  32'(busy1),  32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_data",  32'(data1),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy1), 32'd0);

    // Basic scan, a,b,c,d = 1,0,1,1
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("t2_busy0",  32'(busy1),  32'd1);
    check("t2_sel0",   32'(sel1),   32'd0);
    check("t2_valid0", 32'(valid1), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_sel = (k / 2 > 3) ? 3 : k / 2;
      check($sformatf("t2_sel_e%0d", k),   32'(sel1),   32'(exp_sel));
      check($sformatf("t2_valid_e%0d", k), 32'(valid1), 32'(k == 8));
      check($sformatf("t2_busy_e%0d", k),  32'(busy1),  32'd1);
    end
    check("t2_data", 32'(data1), 32'b1101);

    // Backpressure: word holds while the consumer is not ready
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("t3_valid_c%0d", k), 32'(valid1), 32'd1);
      check($sformatf("t3_data_c%0d", k),  32'(data1),  32'b1101);
      check($sformatf("t3_sel_c%0d", k),   32'(sel1),   32'd3);
    end
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    check("t3_valid_hs", 32'(valid1), 32'd0);
    check("t3_sel_hs",   32'(sel1),   32'd0);
    check("t3_busy_hs",  32'(busy1),  32'(EXP_BUSY_AFTER_HS));

`ifdef MUX_SCAN_CONTINUOUS_EN
    // Back-to-back scans with the consumer always ready
    ready1 = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check($sformatf("t6_valid_e%0d", k), 32'(valid1), 32'((k == 8) || (k == 17)));
      check($sformatf("t6_busy_e%0d", k),  32'(busy1),  32'd1);
      if (k == 8 || k == 17) begin
        check($sformatf("t6_data_e%0d", k), 32'(data1), 32'b1101);
      end
    end
    ready1 = 1'b0;
`else
    // Start pulses during a scan are ignored and do not alter timing
    pat1 = 4'b0110;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      start1 = (k == 3) || (k == 5);
      tick();
      start1 = 1'b0;
      exp_sel = (k / 2 > 3) ? 3 : k / 2;
      check($sformatf("t4_sel_e%0d", k),   32'(sel1),   32'(exp_sel));
      check($sformatf("t4_valid_e%0d", k), 32'(valid1), 32'(k == 8));
    end
    check("t4_data", 32'(data1), 32'b0110);
    // Start coinciding with the handshake is dropped as well
    start1 = 1'b1;
    ready1 = 1'b1;
    tick();
    start1 = 1'b0;
    ready1 = 1'b0;
    check("t4_busy_hs",  32'(busy1),  32'd0);
    check("t4_valid_hs", 32'(valid1), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t4_valid_idle%0d", k), 32'(valid1), 32'd0);
      check($sformatf("t4_busy_idle%0d", k),  32'(busy1),  32'd0);
    end
`endif

    // SETTLE_CYC = 3: four cycles per channel, valid 16 edges after start
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("t5_busy0", 32'(busy3), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_sel = (k / 4 > 3) ? 3 : k / 4;
      check($sformatf("t5_sel_e%0d", k),   32'(sel3),   32'(exp_sel));
      check($sformatf("t5_valid_e%0d", k), 32'(valid3), 32'(k == 16));
    end
    check("t5_data", 32'(data3), 32'b1010);
    ready3 = 1'b1;
    tick();
    ready3 = 1'b0;
    check("t5_valid_hs", 32'(valid3), 32'd0);
    check("t5_sel_hs",   32'(sel3),   32'd0);
    check("t5_busy_hs",  32'(busy3),  32'(EXP_BUSY_AFTER_HS));

    // Asynchronous reset in the middle of a scan
    pat1 = 4'b1101;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    check("t1_busy_pre", 32'(busy1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async_sel",   32'(sel1),   32'd0);
    check("t1_async_busy",  32'(busy1),  32'd0);
    check("t1_async_valid", 32'(valid1), 32'd0);
    check("t1_async_data",  32'(data1),  32'd0);
    check("t1_async_data3", 32'(data3),  32'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("t1_post_valid%0d", k), 32'(valid1), 32'd0);
      check($sformatf("t1_post_busy%0d", k),  32'(busy1),  32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
